apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Synthesizable APB initiator that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers, one at a time.
- Drives `apb_uart_top` (or any APB responder) from on-chip logic such as a CPU stub or DMA sequencer.
- Returns read data, slave error and timeout status on a valid/ready response channel.

Parameters:
- ADDR_W, 32, width of cmd_addr and PADDR
- DATA_W, 32, width of cmd_wdata, PWDATA, PRDATA and rsp_rdata
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles with PREADY low before abort; 0 disables the timeout

Ports:
- PCLK  in  1  sole clock; all logic on rising edge
- PRESET  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- busy  out  1  high in any state other than IDLE
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP.
- All outputs are registered except cmd_ready and busy, which are decoded from state.
- Reset values:
  - State = IDLE.
  - PSELx = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_timeout = 0.
  - Timeout counter = 0.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, register cmd_addr → PADDR, cmd_wdata → PWDATA and cmd_write → PWRITE.
  - At the same edge, set PSELx = 1 and PENABLE = 0, then go to SETUP.
- SETUP:
  - Lasts exactly one cycle.
  - Next edge: PENABLE = 1, clear the timeout counter, go to ACCESS.
- ACCESS:
  - If PREADY = 1, complete the transfer at this edge:
    - rsp_rdata = PWRITE ? 0 : PRDATA.
    - rsp_err = PSLVERR, rsp_timeout = 0.
    - PSELx = 0, PENABLE = 0, rsp_valid = 1, go to RESP.
  - If PREADY = 0, increment the counter.
  - Timeout abort: when TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES-1 with PREADY still 0:
    - rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1.
    - PSELx = 0, PENABLE = 0, rsp_valid = 1, go to RESP.
  - PREADY = 1 in the same cycle as the timeout threshold is a normal completion, not a timeout.
  - PSLVERR is sampled only when PREADY = 1.
- RESP:
  - rsp_valid holds its value, and rsp_* are stable, until rsp_ready.
  - On rsp_ready: rsp_valid = 0, go to IDLE.
  - cmd_ready is 0, so a new command is not accepted in the same cycle.
- PADDR, PWDATA and PWRITE hold their last values between transfers; they change only on command accept.
- cmd_* inputs are ignored outside IDLE.
- Latency with PREADY tied high:
  - Accept edge, then SETUP 1 cycle, ACCESS 1 cycle; rsp_valid is high 2 cycles after the accept edge.
  - Minimum command-to-command spacing is 4 cycles with rsp_ready tied high.
- PRESET asserted mid-transfer (any state): at that edge PSELx/PENABLE drop to 0, any pending response is discarded and all outputs take their reset values.
- APB protocol rules:
  - PENABLE is never 1 while PSELx is 0.
  - PADDR, PWDATA and PWRITE are constant from SETUP through the end of ACCESS.

Test Plan:
- Write 0x0000_0001 ← 0x0000_00A5, PREADY = 1:
  - SETUP cycle has PSELx = 1, PENABLE = 0, PWRITE = 1; next cycle has PENABLE = 1.
  - rsp_valid 2 cycles after accept with rsp_rdata = 0, rsp_err = 0.
- Read 0x0000_0001, PREADY = 1, PRDATA = 0x0000_00A5:
  - rsp_rdata = 0xA5, rsp_err = 0.
  - PADDR stable across SETUP and ACCESS.
- Read with PREADY low for 3 cycles, then high with PRDATA = 0xDEAD_BEEF and PSLVERR = 1:
  - ACCESS lasts 4 cycles.
  - rsp_rdata = 0xDEADBEEF, rsp_err = 1, rsp_timeout = 0.
- TIMEOUT_CYCLES = 16, PREADY held 0:
  - Abort after 16 ACCESS cycles.
  - rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, PSELx = 0.
- Backpressure and command masking:
  - Hold rsp_ready = 0 for 5 cycles with cmd_valid = 1: rsp_* stable, cmd_ready = 0, no second SETUP.
  - Release rsp_ready: IDLE, then the next command is accepted.
- Assert PRESET during ACCESS of a write:
  - Next edge: PSELx = 0, PENABLE = 0, PADDR = 0, rsp_valid = 0, cmd_ready = 1 after PRESET deasserts.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB SETUP/ACCESS transfers, one at a time.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  state_e            state_q, state_d;
  logic              psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d, rerr_q, rerr_d, rto_q, rto_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept, done, expire;
  assign accept = state_q == IDLE && cmd_valid;
  assign done   = state_q == ACCESS && PREADY;
  // A ready response on the threshold cycle wins over the abort.
  assign expire = TIMEOUT_CYCLES != 0 && state_q == ACCESS && !PREADY && cnt_q == CNT_MAX;
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      rto_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      rto_q    <= rto_d;
      cnt_q    <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (done || expire) ? RESP : ACCESS;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = accept ? cmd_write : pwrite_q;
    paddr_d  = accept ? cmd_addr : paddr_q;
    pwdata_d = accept ? cmd_wdata : pwdata_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    rto_d    = rto_q;
    cnt_d    = cnt_q;
    if (accept) begin
      psel_d = 1'b1;
      pen_d  = 1'b0;
    end
    if (state_q == SETUP) begin
      pen_d = 1'b1;
      cnt_d = '0;
    end
    if (state_q == ACCESS) cnt_d = cnt_q + 1'b1;
    if (done || expire) begin
      psel_d   = 1'b0;
      pen_d    = 1'b0;
      rvalid_d = 1'b1;
      rdata_d  = (done && !pwrite_q) ? PRDATA : '0;
      rerr_d   = done ? PSLVERR : 1'b1;
      rto_d    = expire;
    end
    if (state_q == RESP && rsp_ready) rvalid_d = 1'b0;
  end
  assign cmd_ready   = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign PSELx       = psel_q;
  assign PENABLE     = pen_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rvalid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rerr_q;
  assign rsp_timeout = rto_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized APB bridge bench with a response scoreboard and a wait-state responder.
module tb_apb_master_bridge;
  localparam int T = 16;
  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic        PSELx, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;
  logic [31:0] PADDR, PWDATA, PRDATA = '0;
  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  always #5 PCLK = ~PCLK;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
    int          acc;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0, failures = 0, cyc = 0, hold = 0;
  int          cur_w = 0;
  logic [31:0] cur_rd = '0, cur_addr = '0, cur_wdata = '0;
  logic        cur_err = 1'b0, cur_write = 1'b0;
  always @(posedge PCLK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Responder: raises PREADY on the cur_w-th ACCESS cycle (0-based); junk elsewhere.
  initial begin
    int n;
    bit hit;
    n = 0;
    forever begin
      @(negedge PCLK);
      if (PSELx && PENABLE) begin
        hit = n == cur_w;
        PREADY = hit;
        PRDATA = hit ? cur_rd : $urandom;
        PSLVERR = hit ? cur_err : 1'($urandom_range(0, 1));
        n++;
      end else begin
        n = 0;
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
      end
    end
  end
  // Monitor: protocol checks every cycle, scoreboard pop on each new response.
  initial begin
    bit          in_rsp;
    exp_t        e;
    logic [31:0] h_rd;
    logic        h_err, h_to;
    in_rsp = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESET) begin
        if (PENABLE) chk("penable_without_psel", 64'(PSELx), 64'd1);
        if (PSELx) begin
          chk("paddr", 64'(PADDR), 64'(cur_addr));
          chk("pwdata", 64'(PWDATA), 64'(cur_wdata));
          chk("pwrite", 64'(PWRITE), 64'(cur_write));
        end
        if (rsp_valid) begin
          chk("resp_cmd_ready_psel", {62'd0, cmd_ready, PSELx}, 64'd0);
          if (!in_rsp) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_rsp: got response with empty scoreboard");
            end else begin
              e = sb.pop_front();
              chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
              chk("rsp_err", 64'(rsp_err), 64'(e.err));
              chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
              chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
            end
            in_rsp = 1;
            h_rd = rsp_rdata;
            h_err = rsp_err;
            h_to = rsp_timeout;
          end else begin
            chk("rsp_stable", {30'd0, rsp_rdata, rsp_err, rsp_timeout}, {30'd0, h_rd, h_err, h_to});
            if (hold > 0) hold--;
          end
        end else in_rsp = 0;
      end
      rsp_ready = hold > 0 ? 1'b0 : $urandom_range(0, 3) != 0;
    end
  end
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input int w, input logic [31:0] rd, input logic er);
    int   k;
    exp_t x;
    bit   to;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr = a;
    cmd_wdata = d;
    k = 0;
    while (!cmd_ready && k < 300) begin
      @(negedge PCLK);
      k++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, k);
      cmd_valid = 1'b0;
      return;
    end
    cur_write = wr;
    cur_addr = a;
    cur_wdata = d;
    cur_w = w;
    cur_rd = rd;
    cur_err = er;
    @(posedge PCLK);
    @(negedge PCLK);
    to = T != 0 && w >= T;
    x.rdata = (wr || to) ? 32'd0 : rd;
    x.err = to ? 1'b1 : er;
    x.to = to;
    x.lat = 1 + (to ? T : w + 1);
    x.acc = cyc;
    sb.push_back(x);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr = $urandom;
    cmd_wdata = $urandom;
  endtask
  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || rsp_valid) && k < 500) begin
      @(negedge PCLK);
      k++;
    end
    chk("drain_scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask
  initial begin
    int w;
    repeat (3) @(negedge PCLK);
    chk("reset_outs", {55'd0, PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, busy, cmd_ready, 1'b0}, 64'h2);
    chk("reset_paddr_pwdata", {PADDR, PWDATA}, 64'd0);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    PRESET = 1'b0;
    issue(1'b1, 32'h1, 32'hA5, 0, 32'h0, 1'b0);
    chk("setup_phase", {61'd0, PSELx, PENABLE, PWRITE}, 64'b101);
    @(negedge PCLK);
    chk("access_phase", {62'd0, PSELx, PENABLE}, 64'b11);
    issue(1'b0, 32'h1, 32'h0, 0, 32'hA5, 1'b0);
    issue(1'b0, 32'h40, 32'h0, 3, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 32'h80, 32'h0, 1000, 32'h1234, 1'b0);
    hold = 5;
    issue(1'b1, 32'hC0, 32'h55AA, 2, 32'h0, 1'b1);
    issue(1'b0, 32'hC4, 32'h0, T - 1, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, 32'hC8, 32'h0, T, 32'h7777, 1'b0);
    for (int i = 0; i < 150; i++) begin
      w = $urandom_range(0, 9) == 0 ? int'($urandom_range(T - 2, T + 1)) : int'($urandom_range(0, 4));
      issue(1'($urandom_range(0, 1)), $urandom, $urandom, w, $urandom, 1'($urandom_range(0, 1)));
    end
    drain();
    issue(1'b1, 32'hABC0, 32'h1357, 1000, 32'h0, 1'b0);
    @(negedge PCLK);
    chk("pre_reset_access", {62'd0, PSELx, PENABLE}, 64'b11);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("midreset_outs", {58'd0, PSELx, PENABLE, PWRITE, rsp_valid, busy, cmd_ready}, 64'b1);
    chk("midreset_paddr_pwdata", {PADDR, PWDATA}, 64'd0);
    sb.delete();
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    issue(1'b0, 32'h10, 32'h0, 1, 32'h0BAD_CAFE, 1'b0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
